// File: rtl/vga_text_pkg.sv
// Shared timing constants, text-grid geometry and helpers for the VGA text scanner.
package vga_text_pkg;

   localparam int H_ACTIVE = 640;
   localparam int H_FP     = 16;
   localparam int H_SYNC   = 96;
   localparam int H_BP     = 48;
   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int V_ACTIVE = 480;
   localparam int V_FP     = 10;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 33;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int COLS    = 80;
   localparam int ROWS    = 30;
   localparam int GLYPH_W = 8;
   localparam int GLYPH_H = 16;

   localparam int CNT_W        = 10;
   localparam int CHAR_ADDR_W  = 12;
   localparam int CHAR_IDX_W   = 12;
   localparam int GLYPH_ADDR_W = 16;

   typedef struct packed {
      logic active;
      logic hsync;
      logic vsync;
      logic sof;
   } vid_ctrl_t;

   // row*80 + col built from shifts: 80 = 64 + 16.
   function automatic logic [CHAR_ADDR_W-1:0] cell_addr(input logic [CNT_W-1:0] h,
                                                        input logic [CNT_W-1:0] v);
      logic [CHAR_ADDR_W-1:0] row;
      logic [CHAR_ADDR_W-1:0] col;
      row = CHAR_ADDR_W'(v >> 4);
      col = CHAR_ADDR_W'(h >> 3);
      return (row << 6) + (row << 4) + col;
   endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Horizontal/vertical raster counters and the raw (unaligned) video control flags.
module vga_timing_gen #(
   parameter int H_ACTIVE = vga_text_pkg::H_ACTIVE,
   parameter int H_FP     = vga_text_pkg::H_FP,
   parameter int H_SYNC   = vga_text_pkg::H_SYNC,
   parameter int H_BP     = vga_text_pkg::H_BP,
   parameter int V_ACTIVE = vga_text_pkg::V_ACTIVE,
   parameter int V_FP     = vga_text_pkg::V_FP,
   parameter int V_SYNC   = vga_text_pkg::V_SYNC,
   parameter int V_BP     = vga_text_pkg::V_BP
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            pix_en,
   output logic [vga_text_pkg::CNT_W-1:0]  h_cnt,
   output logic [vga_text_pkg::CNT_W-1:0]  v_cnt,
   output vga_text_pkg::vid_ctrl_t         ctrl
);
   import vga_text_pkg::*;

   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] HS_BEGIN = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] VS_BEGIN = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

   // The line counter steps on the same strobe that wraps the pixel counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   always_comb begin
      ctrl        = '0;
      ctrl.active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
      ctrl.hsync  = (h_cnt >= HS_BEGIN) && (h_cnt < HS_END);
      ctrl.vsync  = (v_cnt >= VS_BEGIN) && (v_cnt < VS_END);
      ctrl.sof    = (h_cnt == '0) && (v_cnt == '0);
   end

endmodule

// File: rtl/vga_text_scanner.sv
// 80x30 text-mode scanner: walks the raster, fetches character and glyph rows, and
// serializes pixels with syncs delayed to match the two-read fetch pipeline.
module vga_text_scanner #(
   parameter int   H_ACTIVE = vga_text_pkg::H_ACTIVE,
   parameter int   H_FP     = vga_text_pkg::H_FP,
   parameter int   H_SYNC   = vga_text_pkg::H_SYNC,
   parameter int   H_BP     = vga_text_pkg::H_BP,
   parameter int   V_ACTIVE = vga_text_pkg::V_ACTIVE,
   parameter int   V_FP     = vga_text_pkg::V_FP,
   parameter int   V_SYNC   = vga_text_pkg::V_SYNC,
   parameter int   V_BP     = vga_text_pkg::V_BP,
   parameter logic SYNC_POL = 1'b0
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   pix_en,
   output logic                                   buf_en_o,
   output logic [vga_text_pkg::CHAR_ADDR_W-1:0]   char_addr_o,
   input  logic [vga_text_pkg::CHAR_IDX_W-1:0]    char_idx_i,
   output logic [vga_text_pkg::GLYPH_ADDR_W-1:0]  glyph_addr_o,
   input  logic [vga_text_pkg::GLYPH_W-1:0]       glyph_bits_i,
   output logic                                   pixel_o,
   output logic                                   de_o,
   output logic                                   hsync_o,
   output logic                                   vsync_o,
   output logic                                   sof_o
);
   import vga_text_pkg::*;

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   vid_ctrl_t        ctrl_s0;
   vid_ctrl_t        ctrl_s1;
   vid_ctrl_t        ctrl_s2;
   logic [3:0]       line_s1;
   logic [2:0]       col_s1;
   logic [2:0]       col_s2;

   vga_timing_gen #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_timing (
      .clk    (clk),
      .rst_n  (rst_n),
      .pix_en (pix_en),
      .h_cnt  (h_cnt),
      .v_cnt  (v_cnt),
      .ctrl   (ctrl_s0)
   );

   assign buf_en_o     = pix_en;
   assign char_addr_o  = ctrl_s0.active ? cell_addr(h_cnt, v_cnt) : '0;
   assign glyph_addr_o = {char_idx_i, line_s1};

   // s1 lines up with char_idx_i, s2 with glyph_bits_i; the output registers are the third stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ctrl_s1 <= '0;
         ctrl_s2 <= '0;
         line_s1 <= '0;
         col_s1  <= '0;
         col_s2  <= '0;
         pixel_o <= 1'b0;
         de_o    <= 1'b0;
         hsync_o <= ~SYNC_POL;
         vsync_o <= ~SYNC_POL;
         sof_o   <= 1'b0;
      end else if (pix_en) begin
         ctrl_s1 <= ctrl_s0;
         ctrl_s2 <= ctrl_s1;
         line_s1 <= v_cnt[3:0];
         col_s1  <= h_cnt[2:0];
         col_s2  <= col_s1;
         pixel_o <= glyph_bits_i[3'd7 - col_s2] & ctrl_s2.active;
         de_o    <= ctrl_s2.active;
         hsync_o <= ctrl_s2.hsync ? SYNC_POL : ~SYNC_POL;
         vsync_o <= ctrl_s2.vsync ? SYNC_POL : ~SYNC_POL;
         sof_o   <= ctrl_s2.sof;
      end
   end

endmodule

// File: tb/tb_vga_text_scanner.sv
// Scoreboard bench for vga_text_scanner with a shortened vertical raster and memory models.
module tb_vga_text_scanner;
   import vga_text_pkg::*;

   localparam int TB_HA = 640;
   localparam int TB_HFP = 16;
   localparam int TB_HS = 96;
   localparam int TB_HBP = 48;
   localparam int TB_HT = TB_HA + TB_HFP + TB_HS + TB_HBP;
   localparam int TB_VA = 40;
   localparam int TB_VFP = 2;
   localparam int TB_VS = 2;
   localparam int TB_VBP = 2;
   localparam int TB_VT = TB_VA + TB_VFP + TB_VS + TB_VBP;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_en = 1'b0;
   logic        buf_en_o;
   logic [11:0] char_addr_o;
   logic [11:0] char_idx_i = '0;
   logic [15:0] glyph_addr_o;
   logic [7:0]  glyph_bits_i = '0;
   logic        pixel_o, de_o, hsync_o, vsync_o, sof_o;

   int checks = 0;
   int errors = 0;
   logic [4:0]  exp_q[$];
   logic [11:0] text_mem [0:2399];
   bit          pat_mode = 1'b0;
   int          mh = 0;
   int          mv = 0;

   bit          mon_last_en = 1'b0;
   bit          mon_last_rst = 1'b1;
   logic [16:0] held = '0;
   int          mon_idx, hs_first, hs_second, hs_width, sof_cnt, sof_first, sof_second;
   bit          hs_prev;

   vga_text_scanner #(
      .H_ACTIVE (TB_HA), .H_FP (TB_HFP), .H_SYNC (TB_HS), .H_BP (TB_HBP),
      .V_ACTIVE (TB_VA), .V_FP (TB_VFP), .V_SYNC (TB_VS), .V_BP (TB_VBP),
      .SYNC_POL (1'b0)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pix_en       (pix_en),
      .buf_en_o     (buf_en_o),
      .char_addr_o  (char_addr_o),
      .char_idx_i   (char_idx_i),
      .glyph_addr_o (glyph_addr_o),
      .glyph_bits_i (glyph_bits_i),
      .pixel_o      (pixel_o),
      .de_o         (de_o),
      .hsync_o      (hsync_o),
      .vsync_o      (vsync_o),
      .sof_o        (sof_o)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] font_fn(input logic [15:0] a);
      logic [31:0] t;
      t = {16'h0, a} * 32'h9E3779B1;
      return t[23:16];
   endfunction

   // Reference model: what the screen shows at raster position (h,v), as {pixel,de,hsync,vsync,sof}.
   function automatic logic [4:0] model_out(input int h, input int v);
      logic act, hs, vs, sof, pix;
      logic [11:0] idx;
      logic [7:0]  bits;
      logic [3:0]  ln;
      act  = (h < TB_HA) && (v < TB_VA);
      hs   = (h >= TB_HA + TB_HFP) && (h < TB_HA + TB_HFP + TB_HS);
      vs   = (v >= TB_VA + TB_VFP) && (v < TB_VA + TB_VFP + TB_VS);
      sof  = (h == 0) && (v == 0);
      pix  = 1'b0;
      idx  = '0;
      bits = '0;
      if (act) begin
         idx  = pat_mode ? 12'h041 : text_mem[(v / 16) * COLS + h / 8];
         ln   = 4'(v % 16);
         bits = pat_mode ? 8'hA5 : font_fn({idx, ln});
         pix  = bits[7 - (h % 8)];
      end
      return {pix, act, ~hs, ~vs, sof};
   endfunction

   function automatic int model_addr(input int h, input int v);
      return ((h < TB_HA) && (v < TB_VA)) ? (v / 16) * COLS + h / 8 : 0;
   endfunction

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Text buffer and font ROM: one-enabled-cycle read latency.
   always @(posedge clk) begin
      if (buf_en_o)
         char_idx_i <= pat_mode ? 12'h041 :
                       ((char_addr_o < 12'd2400) ? text_mem[char_addr_o] : 12'hFFF);
   end

   always @(posedge clk) begin
      if (pix_en)
         glyph_bits_i <= pat_mode ? 8'hA5 : font_fn(glyph_addr_o);
   end

   // Monitor: one expected entry per enabled edge; outputs must hold across disabled edges.
   always @(posedge clk) begin
      mon_last_en  = pix_en;
      mon_last_rst = !rst_n;
   end

   always @(negedge clk) begin : monitor
      logic [4:0] act;
      logic [4:0] req;
      act = {pixel_o, de_o, hsync_o, vsync_o, sof_o};
      if (!mon_last_rst) begin
         if (mon_last_en) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL exp_q_empty actual=%0d required=%0d", act, 0);
            end else begin
               req = exp_q.pop_front();
               check("video", int'(act), int'(req));
               mon_idx++;
               if (hsync_o == 1'b0) begin
                  if (!hs_prev) begin
                     if (hs_first < 0) hs_first = mon_idx;
                     else if (hs_second < 0) hs_second = mon_idx;
                  end
                  if (hs_second < 0) hs_width++;
               end
               hs_prev = (hsync_o == 1'b0);
               if (sof_o) begin
                  sof_cnt++;
                  if (sof_first < 0) sof_first = mon_idx;
                  else if (sof_second < 0) sof_second = mon_idx;
               end
            end
         end else begin
            check("hold", int'(held), int'({act, char_addr_o}));
         end
      end
      held = {act, char_addr_o};
   end

   task automatic step(input bit en);
      pix_en = en;
      #1;
      check("buf_en", int'(buf_en_o), int'(en));
      if (en) begin
         check("char_addr", int'(char_addr_o), model_addr(mh, mv));
         exp_q.push_back(model_out(mh, mv));
         mh++;
         if (mh == TB_HT) begin
            mh = 0;
            mv++;
            if (mv == TB_VT) mv = 0;
         end
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset(input bit new_pat);
      rst_n  = 1'b0;
      pix_en = 1'b1;
      @(posedge clk);
      @(negedge clk);
      exp_q.delete();
      pat_mode   = new_pat;
      mh         = 0;
      mv         = 0;
      mon_idx    = 0;
      hs_first   = -1;
      hs_second  = -1;
      hs_width   = 0;
      hs_prev    = 1'b0;
      sof_cnt    = 0;
      sof_first  = -1;
      sof_second = -1;
      check("rst_pixel", int'(pixel_o), 0);
      check("rst_de", int'(de_o), 0);
      check("rst_sof", int'(sof_o), 0);
      check("rst_hsync", int'(hsync_o), 1);
      check("rst_vsync", int'(vsync_o), 1);
      check("rst_addr", int'(char_addr_o), 0);
      exp_q.push_back(5'b00110);
      exp_q.push_back(5'b00110);
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < 2400; i++) text_mem[i] = 12'($urandom);
      repeat (3) @(negedge clk);

      // Full-rate sweep: one whole frame, then into the next up to v=20, h=300.
      do_reset(1'b0);
      for (int i = 0; i < TB_HT * TB_VT + 20 * TB_HT + 300; i++) step(1'b1);
      check("hs_first", hs_first, 656 + 3);
      check("hs_width", hs_width, TB_HS);
      check("line_period", hs_second - hs_first, TB_HT);
      check("sof_count", sof_cnt, 2);
      check("frame_period", sof_second - sof_first, TB_HT * TB_VT);

      // Mid-frame reset, then the fixed 0x041 / 0xA5 pattern under gated strobes.
      do_reset(1'b1);
      for (int i = 0; i < 4 * 2 * TB_HT; i++) step((i % 4) == 0);
      for (int i = 0; i < 2 * TB_HT; i++) step($urandom_range(0, 1) == 1);
      check("restart_sof", sof_first, 3);
      check("restart_sof_once", sof_cnt, 1);
      check("restart_hs_first", hs_first, 656 + 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
